// File: rtl/gem_ext_fifo_tx_pkt_buf.sv
// Store-and-forward Tx frame buffer: a frame is released downstream only once it is fully stored.
// Optional statistics counters are enabled with `define GEM_TX_PKT_BUF_STATS_EN.
module gem_ext_fifo_tx_pkt_buf #(
    parameter int ADDR_W      = 11,
    parameter int FRAME_CNT_W = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tuser,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   err_drop,
    output logic                   ovf_drop
`ifdef GEM_TX_PKT_BUF_STATS_EN
    ,
    output logic [31:0]            stat_frames_out,
    output logic [31:0]            stat_frames_drop
`endif
);

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_ACTIVE  = 2'd1,
        WR_DISCARD = 2'd2
    } wr_state_t;

    localparam logic [ADDR_W-1:0]      PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0]      PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [FRAME_CNT_W-1:0] CNT_ONE = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [FRAME_CNT_W-1:0] CNT_MAX = {FRAME_CNT_W{1'b1}};

    wr_state_t         wr_state_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] wr_cmt_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [8:0]        mem_r [0:(1<<ADDR_W)-1];
    logic [8:0]        rd_q_r;

    logic accept_s;
    logic full_s;
    logic wr_en_s;
    logic commit_s;
    logic rd_en_s;
    logic pop_last_s;

    // Discard mode keeps draining the upstream even when the frame counter is saturated.
    assign s_axis_tready = !reset && ((wr_state_r == WR_DISCARD) || (frame_count != CNT_MAX));
    assign accept_s      = s_axis_tvalid && s_axis_tready;
    assign full_s        = ((wr_ptr_r + PTR_ONE) == rd_ptr_r);
    assign wr_en_s       = accept_s && (wr_state_r != WR_DISCARD) && !full_s;
    assign commit_s      = wr_en_s && s_axis_tlast && !s_axis_tuser;
    // The RAM output register is the output stage, so it only advances when empty or consumed.
    assign rd_en_s       = (rd_ptr_r != wr_cmt_r) && (!m_axis_tvalid || m_axis_tready);
    assign pop_last_s    = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign m_axis_tdata  = rd_q_r[7:0];
    assign m_axis_tlast  = rd_q_r[8];

    // Byte storage write port; only bytes beyond the committed pointer are ever written.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // Read pointer and registered read data forming the output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r      <= PTR_ZERO;
            rd_q_r        <= 9'd0;
            m_axis_tvalid <= 1'b0;
        end else if (rd_en_s) begin
            rd_q_r        <= mem_r[rd_ptr_r];
            rd_ptr_r      <= rd_ptr_r + PTR_ONE;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Write FSM: stores, commits, or rewinds the frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_r <= WR_IDLE;
            wr_ptr_r   <= PTR_ZERO;
            wr_cmt_r   <= PTR_ZERO;
            err_drop   <= 1'b0;
            ovf_drop   <= 1'b0;
        end else begin
            err_drop <= 1'b0;
            ovf_drop <= 1'b0;
            case (wr_state_r)
                WR_IDLE, WR_ACTIVE: begin
                    if (accept_s) begin
                        if (full_s) begin
                            wr_ptr_r <= wr_cmt_r;
                            if (s_axis_tlast) begin
                                ovf_drop   <= 1'b1;
                                wr_state_r <= WR_IDLE;
                            end else begin
                                wr_state_r <= WR_DISCARD;
                            end
                        end else if (s_axis_tlast) begin
                            wr_state_r <= WR_IDLE;
                            if (s_axis_tuser) begin
                                wr_ptr_r <= wr_cmt_r;
                                err_drop <= 1'b1;
                            end else begin
                                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                                wr_cmt_r <= wr_ptr_r + PTR_ONE;
                            end
                        end else begin
                            wr_ptr_r   <= wr_ptr_r + PTR_ONE;
                            wr_state_r <= WR_ACTIVE;
                        end
                    end
                end
                WR_DISCARD: begin
                    if (accept_s && s_axis_tlast) begin
                        ovf_drop   <= 1'b1;
                        wr_state_r <= WR_IDLE;
                    end
                end
                default: wr_state_r <= WR_IDLE;
            endcase
        end
    end

    // Committed-frame counter; a commit and a last-byte handshake in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= {FRAME_CNT_W{1'b0}};
        end else begin
            case ({commit_s, pop_last_s})
                2'b10:   frame_count <= frame_count + CNT_ONE;
                2'b01:   frame_count <= frame_count - CNT_ONE;
                default: frame_count <= frame_count;
            endcase
        end
    end

`ifdef GEM_TX_PKT_BUF_STATS_EN
    // Free-running statistics, wrapping at 2**32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_frames_out  <= 32'd0;
            stat_frames_drop <= 32'd0;
        end else begin
            if (pop_last_s) begin
                stat_frames_out <= stat_frames_out + 32'd1;
            end
            if (err_drop || ovf_drop) begin
                stat_frames_drop <= stat_frames_drop + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gem_ext_fifo_tx_pkt_buf.sv
// Bench for gem_ext_fifo_tx_pkt_buf: frame-level scoreboard model plus directed scenarios.
// Two instances: default depth (2047 bytes) and ADDR_W=6 (63 bytes), selected by sel.
module tb_gem_ext_fifo_tx_pkt_buf;
    localparam int CNT_MAX = 63;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] s_tdata = 8'd0;
    logic       s_tvalid = 1'b0;
    logic       s_tlast = 1'b0;
    logic       s_tuser = 1'b0;
    logic       m_tready = 1'b0;
    logic       sel = 1'b0;

    logic       a_s_tready, b_s_tready, a_m_tvalid, b_m_tvalid, a_m_tlast, b_m_tlast;
    logic [7:0] a_m_tdata, b_m_tdata;
    logic [5:0] a_count, b_count;
    logic       a_err, b_err, a_ovf, b_ovf;
`ifdef GEM_TX_PKT_BUF_STATS_EN
    logic [31:0] a_stat_out, a_stat_drop, b_stat_out, b_stat_drop;
`endif

    logic       s_tready, m_tvalid, m_tlast, err_drop, ovf_drop;
    logic [7:0] m_tdata;
    logic [5:0] frame_count;

    assign s_tready    = sel ? b_s_tready : a_s_tready;
    assign m_tvalid    = sel ? b_m_tvalid : a_m_tvalid;
    assign m_tlast     = sel ? b_m_tlast  : a_m_tlast;
    assign m_tdata     = sel ? b_m_tdata  : a_m_tdata;
    assign frame_count = sel ? b_count    : a_count;
    assign err_drop    = sel ? b_err      : a_err;
    assign ovf_drop    = sel ? b_ovf      : a_ovf;

    gem_ext_fifo_tx_pkt_buf #(.ADDR_W(11), .FRAME_CNT_W(6)) dut_a (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && !sel), .s_axis_tready(a_s_tready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(a_m_tlast), .frame_count(a_count), .err_drop(a_err), .ovf_drop(a_ovf)
`ifdef GEM_TX_PKT_BUF_STATS_EN
        , .stat_frames_out(a_stat_out), .stat_frames_drop(a_stat_drop)
`endif
    );

    gem_ext_fifo_tx_pkt_buf #(.ADDR_W(6), .FRAME_CNT_W(6)) dut_b (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && sel), .s_axis_tready(b_s_tready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(b_m_tlast), .frame_count(b_count), .err_drop(b_err), .ovf_drop(b_ovf)
`ifdef GEM_TX_PKT_BUF_STATS_EN
        , .stat_frames_out(b_stat_out), .stat_frames_drop(b_stat_drop)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard state: committed bytes awaiting output, frame in progress, expected pulses.
    logic [8:0] exp_q[$];
    logic [8:0] cur_q[$];
    bit         cur_ovf = 1'b0;
    int         mcount = 0;
    bit         exp_err = 1'b0;
    bit         exp_ovf = 1'b0;
    int         err_seen = 0;
    int         ovf_seen = 0;
    int         frames_seen = 0;
    bit         stall_prev = 1'b0;
    logic [8:0] stall_data = 9'd0;
    int         cap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model compare and update, once per cycle on the inactive edge.
    always @(negedge clk) begin
        cap = sel ? 63 : 2047;
        if (reset) begin
            chk("tready_in_reset", {31'd0, s_tready}, 32'd0);
            exp_q.delete();
            cur_q.delete();
            cur_ovf    = 1'b0;
            mcount     = 0;
            exp_err    = 1'b0;
            exp_ovf    = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk("frame_count", {26'd0, frame_count}, mcount);
            chk("err_drop", {31'd0, err_drop}, {31'd0, exp_err});
            chk("ovf_drop", {31'd0, ovf_drop}, {31'd0, exp_ovf});
            if (err_drop) err_seen++;
            if (ovf_drop) ovf_seen++;
            if (mcount != CNT_MAX) chk("s_tready", {31'd0, s_tready}, 32'd1);
            if (stall_prev) chk("stall_hold", {22'd0, m_tvalid, m_tlast, m_tdata}, {22'd0, 1'b1, stall_data});
            exp_err = 1'b0;
            exp_ovf = 1'b0;
            if (m_tvalid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", {31'd0, m_tvalid}, 32'd0);
                end else if (m_tready) begin
                    chk("m_byte", {23'd0, m_tlast, m_tdata}, {23'd0, exp_q[0]});
                    if (exp_q[0][8]) begin
                        mcount--;
                        frames_seen++;
                    end
                    void'(exp_q.pop_front());
                end
            end
            stall_prev = m_tvalid && !m_tready;
            stall_data = {m_tlast, m_tdata};
            if (s_tvalid && s_tready) begin
                if (!cur_ovf) begin
                    if (cur_q.size() >= cap - exp_q.size()) cur_ovf = 1'b1;
                    else cur_q.push_back({s_tlast, s_tdata});
                end
                if (s_tlast) begin
                    if (cur_ovf) exp_ovf = 1'b1;
                    else if (s_tuser) exp_err = 1'b1;
                    else begin
                        foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                        mcount++;
                    end
                    cur_q.delete();
                    cur_ovf = 1'b0;
                end
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
        int  n;
        bit  ok;
        n = 0;
        s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
        do begin
            @(negedge clk);
            ok = s_tready;
            if (!ok) begin
                n++;
                @(posedge clk);
            end
        end while (!ok && n < 1000);
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit bad, input int base);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d = 8'(base + i);
            send_beat(d, (i == len - 1), bad && (i == len - 1));
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        int f0;
        int n;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // 1: 64-byte good frame, exact output latency.
        m_tready = 1'b1;
        send_frame(64, 1'b0, 8'h10);
        @(negedge clk);
        chk("lat_n1_valid", {31'd0, m_tvalid}, 32'd0);
        chk("lat_n1_count", {26'd0, frame_count}, 32'd1);
        @(negedge clk);
        chk("lat_n2_valid", {31'd0, m_tvalid}, 32'd1);
        chk("first_byte", {24'd0, m_tdata}, 32'h10);
        drain(200);
        chk("t1_count", {26'd0, frame_count}, 32'd0);
        chk("t1_frames", frames_seen, 32'd1);

        // 2: bad frame dropped, then a good frame.
        send_frame(100, 1'b1, 8'h20);
        repeat (3) @(negedge clk);
        chk("t2_err_seen", err_seen, 32'd1);
        chk("t2_no_valid", {31'd0, m_tvalid}, 32'd0);
        @(posedge clk); #1;
        send_frame(10, 1'b0, 8'hC0);
        drain(100);
        chk("t2_frames", frames_seen, 32'd2);

        // 3: 63-byte instance: 80-byte frame overflows, 63-byte frame fits exactly.
        sel = 1'b1;
        send_frame(80, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        chk("t3_ovf_seen", ovf_seen, 32'd1);
        chk("t3_no_valid", {31'd0, m_tvalid}, 32'd0);
        @(posedge clk); #1;
        send_frame(63, 1'b0, 8'h50);
        drain(200);
        chk("t3_frames", frames_seen, 32'd3);
        sel = 1'b0;

        // 4: stalled output with three queued frames, then random stalls.
        m_tready = 1'b0;
        send_frame(20, 1'b0, 8'h40);
        send_frame(20, 1'b0, 8'h60);
        send_frame(20, 1'b0, 8'h80);
        repeat (4) begin
            @(negedge clk);
            chk("t4_count", {26'd0, frame_count}, 32'd3);
            chk("t4_first", {23'd0, m_tvalid, m_tdata}, {23'd0, 1'b1, 8'h40});
        end
        @(posedge clk); #1;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            m_tready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        m_tready = 1'b1;
        drain(100);
        chk("t4_frames", frames_seen, 32'd6);

        // 5: reset in the middle of a frame while a committed frame is waiting.
        m_tready = 1'b0;
        send_frame(3, 1'b0, 8'hE0);
        for (int i = 0; i < 29; i++) send_beat(8'(8'h90 + i), 1'b0, 1'b0);
        s_tdata = 8'hAD; s_tvalid = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
        chk("rst_err", {31'd0, err_drop}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_drop}, 32'd0);
        chk("rst_count", {26'd0, frame_count}, 32'd0);
        chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
        f0 = frames_seen;
        send_frame(12, 1'b0, 8'hA0);
        drain(100);
        chk("t5_frames", frames_seen - f0, 32'd1);

`ifdef GEM_TX_PKT_BUF_STATS_EN
        // 6: statistics after 5 good and 2 bad frames.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 7; k++) send_frame((k == 2 || k == 5) ? 4 : 6, (k == 2 || k == 5), 16 * k);
        drain(200);
        chk("stat_out", a_stat_out, 32'd5);
        chk("stat_drop", a_stat_drop, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
